// File: rtl/lbf_pkg.sv
// Shared types and constants for the line buffer feeder.
package lbf_pkg;

   localparam int unsigned LB_DEPTH  = 10;
   localparam int unsigned LB_GROUPS = 5;
   localparam int unsigned LB_ROW_W  = 5120;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRIME   = 3'd1,
      SETTLE  = 3'd2,
      WAIT    = 3'd3,
      ADVANCE = 3'd4,
      FINISH  = 3'd5
   } lbf_state_e;

   // Rows needed to fill the window before it is first valid.
   function automatic int unsigned prime_rows(input logic grouped, input int unsigned total);
      int unsigned cap;
      cap = grouped ? 32'd1 : LB_DEPTH;
      return (total < cap) ? total : cap;
   endfunction

endpackage

// File: rtl/lbf_row_seq.sv
// Row walker: latches the operation config and classifies the next row to issue.
// Padding support is compiled in with LBF_PAD_EN.
module lbf_row_seq
   import lbf_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned CNT_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              issue,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  row_cnt,
`ifdef LBF_PAD_EN
   input  logic [3:0]        pad_top,
   input  logic [3:0]        pad_bottom,
   output logic              is_zero_c,
`endif
   output logic [ADDR_W-1:0] addr_c,
   output logic              last_c,
   output logic              prime_end_c,
   output logic              empty_c
);

   // One extra bit so pad_top + row_cnt + pad_bottom never overflows.
   localparam int unsigned T_W = CNT_W + 1;

   logic              mode_q;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [T_W-1:0]    idx_q;

   logic              mode_cur;
   logic [ADDR_W-1:0] base_cur;
   logic [CNT_W-1:0]  cnt_cur;
   logic [T_W-1:0]    idx_cur;
   logic [T_W-1:0]    total_c;

   // On the load cycle the live inputs stand in for the not-yet-latched config.
   assign mode_cur = load ? mode      : mode_q;
   assign base_cur = load ? base_addr : base_q;
   assign cnt_cur  = load ? row_cnt   : cnt_q;
   assign idx_cur  = load ? '0        : idx_q;

`ifdef LBF_PAD_EN
   logic [3:0]     pt_q;
   logic [3:0]     pb_q;
   logic [3:0]     pt_eff;
   logic [3:0]     pb_eff;
   logic [T_W-1:0] img_lo;
   logic [T_W-1:0] img_hi;

   // Grouped mode never pads.
   assign pt_eff    = mode_cur ? 4'd0 : (load ? pad_top    : pt_q);
   assign pb_eff    = mode_cur ? 4'd0 : (load ? pad_bottom : pb_q);
   assign img_lo    = T_W'(pt_eff);
   assign img_hi    = img_lo + T_W'(cnt_cur);
   assign total_c   = img_hi + T_W'(pb_eff);
   assign is_zero_c = (idx_cur < img_lo) || (idx_cur >= img_hi);
   assign addr_c    = base_cur + ADDR_W'(idx_cur - img_lo);
`else
   assign total_c   = T_W'(cnt_cur);
   assign addr_c    = base_cur + ADDR_W'(idx_cur);
`endif

   assign last_c      = (idx_cur == total_c - T_W'(1));
   assign empty_c     = (total_c == '0);
   assign prime_end_c = (32'(idx_cur) == prime_rows(mode_cur, 32'(total_c)) - 32'd1);

   // Config latch and row index; index restarts on load and steps on each issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= 1'b0;
         base_q <= '0;
         cnt_q  <= '0;
         idx_q  <= '0;
`ifdef LBF_PAD_EN
         pt_q   <= 4'd0;
         pb_q   <= 4'd0;
`endif
      end else begin
         if (load) begin
            mode_q <= mode;
            base_q <= base_addr;
            cnt_q  <= row_cnt;
`ifdef LBF_PAD_EN
            pt_q   <= pad_top;
            pb_q   <= pad_bottom;
`endif
         end
         if (load || issue) begin
            idx_q <= idx_cur + T_W'(issue);
         end
      end
   end

endmodule

// File: rtl/line_buffer_feeder.sv
// Write-side sequencer for the 10-row line buffer: fetches rows from the row
// SRAMs, drives buffer_we/fill_zero, and paces the window against consumer steps.
// Optional zero-row padding is enabled with LBF_PAD_EN.
module line_buffer_feeder
   import lbf_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned CNT_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  row_cnt,
   input  logic [3:0]        pad_top,
   input  logic [3:0]        pad_bottom,
   input  logic              step,
   output logic              sram_re,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              buffer_mode,
   output logic              buffer_we,
   output logic              fill_zero,
   output logic              window_valid,
   output logic              busy,
   output logic              done
);

   lbf_state_e        state_q;
   logic              iss_q;
   logic              all_iss_q;
   logic              prime_done_q;

   logic              load_c;
   logic              issue_c;
   logic              row_zero_c;
   logic [ADDR_W-1:0] row_addr_c;
   logic              row_last_c;
   logic              row_prime_end_c;
   logic              row_empty_c;

`ifdef LBF_PAD_EN
   logic              iss_zero_q;
`else
   logic              pad_unused_c;

   // Padding inputs have no function in this build.
   assign pad_unused_c = ^{pad_top, pad_bottom};
   assign row_zero_c   = 1'b0;
   assign fill_zero    = 1'b0;
`endif

   lbf_row_seq #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_row_seq (
      .clk         (clk),
      .rst         (rst),
      .load        (load_c),
      .issue       (issue_c),
      .mode        (mode),
      .base_addr   (base_addr),
      .row_cnt     (row_cnt),
`ifdef LBF_PAD_EN
      .pad_top     (pad_top),
      .pad_bottom  (pad_bottom),
      .is_zero_c   (row_zero_c),
`endif
      .addr_c      (row_addr_c),
      .last_c      (row_last_c),
      .prime_end_c (row_prime_end_c),
      .empty_c     (row_empty_c)
   );

   // Decide whether a row is issued in the coming cycle.
   always_comb begin
      load_c  = 1'b0;
      issue_c = 1'b0;
      case (state_q)
         IDLE: begin
            load_c  = start;
            issue_c = start && !row_empty_c;
         end
         PRIME:   issue_c = !prime_done_q;
         WAIT:    issue_c = step && !all_iss_q;
         default: issue_c = 1'b0;
      endcase
   end

   // Control FSM with registered outputs; writes trail each issue by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sram_re      <= 1'b0;
         sram_addr    <= '0;
         buffer_mode  <= 1'b0;
         buffer_we    <= 1'b0;
         window_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         iss_q        <= 1'b0;
         all_iss_q    <= 1'b0;
         prime_done_q <= 1'b0;
`ifdef LBF_PAD_EN
         fill_zero    <= 1'b0;
         iss_zero_q   <= 1'b0;
`endif
      end else begin
         sram_re   <= 1'b0;
         buffer_we <= iss_q;
         done      <= 1'b0;
         iss_q     <= issue_c;
`ifdef LBF_PAD_EN
         fill_zero  <= iss_q & iss_zero_q;
         iss_zero_q <= issue_c & row_zero_c;
`endif
         if (issue_c) begin
            sram_re      <= !row_zero_c;
            sram_addr    <= row_addr_c;
            all_iss_q    <= row_last_c;
            prime_done_q <= row_prime_end_c;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  buffer_mode <= mode;
                  if (row_empty_c) begin
                     state_q <= FINISH;
                     done    <= 1'b1;
                  end else begin
                     state_q <= PRIME;
                     busy    <= 1'b1;
                  end
               end
            end
            PRIME: begin
               if (prime_done_q) begin
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               state_q      <= WAIT;
               window_valid <= 1'b1;
            end
            WAIT: begin
               if (step) begin
                  window_valid <= 1'b0;
                  if (all_iss_q) begin
                     state_q <= FINISH;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     state_q <= ADVANCE;
                  end
               end
            end
            ADVANCE: state_q <= SETTLE;
            FINISH:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Scoreboard bench for line_buffer_feeder; follows LBF_PAD_EN when deciding padding.
module tb_line_buffer_feeder;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned CNT_W  = 11;
   localparam int          MAXR   = 64;
`ifdef LBF_PAD_EN
   localparam bit PAD_ON = 1'b1;
`else
   localparam bit PAD_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              mode;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  row_cnt;
   logic [3:0]        pad_top;
   logic [3:0]        pad_bottom;
   logic              step;
   logic              sram_re;
   logic [ADDR_W-1:0] sram_addr;
   logic              buffer_mode;
   logic              buffer_we;
   logic              fill_zero;
   logic              window_valid;
   logic              busy;
   logic              done;

   line_buffer_feeder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mode         (mode),
      .base_addr    (base_addr),
      .row_cnt      (row_cnt),
      .pad_top      (pad_top),
      .pad_bottom   (pad_bottom),
      .step         (step),
      .sram_re      (sram_re),
      .sram_addr    (sram_addr),
      .buffer_mode  (buffer_mode),
      .buffer_we    (buffer_we),
      .fill_zero    (fill_zero),
      .window_valid (window_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int exp_addr[$];
   bit exp_zero[$];

   bit m_zero [MAXR];
   int m_addr [MAXR];
   int m_t;
   int m_p;
   int m_next;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst   = 1'b1;
      start = 1'b0;
      step  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      exp_addr.delete();
      exp_zero.delete();
   endtask

   // Reference row list for one operation.
   task automatic model_setup(input bit m, input int base, input int cnt, input int pt, input int pb);
      int pte;
      int pbe;
      pte = (PAD_ON && !m) ? pt : 0;
      pbe = (PAD_ON && !m) ? pb : 0;
      m_t = pte + cnt + pbe;
      if (m) m_p = (m_t < 1) ? m_t : 1;
      else   m_p = (m_t < 10) ? m_t : 10;
      for (int r = 0; r < MAXR; r++) begin
         m_zero[r] = (r < pte) || (r >= pte + cnt);
         m_addr[r] = (base + r - pte) & 1023;
      end
      m_next = 0;
   endtask

   task automatic push_rows(input int n);
      for (int i = 0; i < n; i++) begin
         if (m_next < m_t) begin
            exp_zero.push_back(m_zero[m_next]);
            if (!m_zero[m_next]) exp_addr.push_back(m_addr[m_next]);
            m_next++;
         end
      end
   endtask

   // Scoreboard: every read and every buffer write is matched against the queues.
   always @(negedge clk) begin : mon
      int a;
      bit z;
      if (!rst) begin
         if (sram_re) begin
            n_checks++;
            if (exp_addr.size() == 0) begin
               $display("FAIL sram_addr: got read of %0d, want no read", sram_addr);
            end else begin
               a = exp_addr.pop_front();
               if (int'(sram_addr) !== a) $display("FAIL sram_addr: got %0d want %0d", sram_addr, a);
               else n_pass++;
            end
            n_checks++;
            if (window_valid !== 1'b0) $display("FAIL re_vs_valid: window_valid %0b with sram_re", window_valid);
            else n_pass++;
         end
         if (buffer_we) begin
            n_checks++;
            if (exp_zero.size() == 0) begin
               $display("FAIL buffer_we: got write, want none");
            end else begin
               z = exp_zero.pop_front();
               if (fill_zero !== z) $display("FAIL fill_zero: got %0b want %0b", fill_zero, z);
               else n_pass++;
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; step = 1'b0; mode = 1'b0;
      base_addr = '0; row_cnt = '0; pad_top = '0; pad_bottom = '0;
      tick(); tick(); tick();
      n_checks++;
      if ({sram_re, buffer_mode, buffer_we, fill_zero, window_valid, busy, done} !== 7'd0)
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {sram_re, buffer_mode, buffer_we, fill_zero, window_valid, busy, done});
      else n_pass++;
      n_checks++;
      if (sram_addr !== '0) $display("FAIL reset_addr: got %0d want 0", sram_addr);
      else n_pass++;
      rst = 1'b0;
   endtask

   // One full operation: priming, every step, final done. noise holds start and steps in PRIME.
   task automatic test_operation(input string name, input bit m, input int base, input int cnt,
                                 input int pt, input int pb, input bit noise, input bit do_reset);
      bit exp_re;
      bit exp_we;
      bit exp_wv;
      int r;
      if (do_reset) reset_dut();
      model_setup(m, base, cnt, pt, pb);
      push_rows(m_p);
      mode = m; base_addr = ADDR_W'(base); row_cnt = CNT_W'(cnt);
      pad_top = 4'(pt); pad_bottom = 4'(pb);
      start = 1'b1;
      tick();
      start = noise; step = noise; mode = ~m;
      base_addr = base_addr + 10'd37; row_cnt = row_cnt + 11'd5;
      pad_top = 4'd7; pad_bottom = 4'd9;
      for (int c = 1; c <= m_p + 2; c++) begin
         if (c == m_p + 1) step = 1'b0;
         exp_re = (c <= m_p) && !m_zero[c-1];
         exp_we = (c >= 2) && (c <= m_p + 1);
         exp_wv = (c == m_p + 2);
         n_checks++;
         if (sram_re !== exp_re) $display("FAIL %s sram_re c%0d: got %0b want %0b", name, c, sram_re, exp_re);
         else n_pass++;
         n_checks++;
         if (buffer_we !== exp_we) $display("FAIL %s buffer_we c%0d: got %0b want %0b", name, c, buffer_we, exp_we);
         else n_pass++;
         n_checks++;
         if (window_valid !== exp_wv) $display("FAIL %s window_valid c%0d: got %0b want %0b", name, c, window_valid, exp_wv);
         else n_pass++;
         if (c == 1) begin
            n_checks++;
            if ({busy, buffer_mode, done} !== {1'b1, m, 1'b0})
               $display("FAIL %s busy_mode_done c1: got %b want %b", name, {busy, buffer_mode, done}, {1'b1, m, 1'b0});
            else n_pass++;
         end
         if (c < m_p + 2) tick();
      end
      for (int k = 0; k < m_t - m_p; k++) begin
         r = m_next;
         push_rows(1);
         step = 1'b1;
         tick();
         step = 1'b0;
         n_checks++;
         if ({window_valid, sram_re} !== {1'b0, !m_zero[r]})
            $display("FAIL %s adv%0d s+1: got wv/re %b want %b", name, k, {window_valid, sram_re}, {1'b0, !m_zero[r]});
         else n_pass++;
         tick();
         n_checks++;
         if ({buffer_we, window_valid} !== 2'b10)
            $display("FAIL %s adv%0d s+2: got we/wv %b want 10", name, k, {buffer_we, window_valid});
         else n_pass++;
         tick();
         n_checks++;
         if (window_valid !== 1'b1) $display("FAIL %s adv%0d s+3: got wv %0b want 1", name, k, window_valid);
         else n_pass++;
      end
      start = 1'b0;
      step  = 1'b1;
      tick();
      step = 1'b0;
      n_checks++;
      if ({done, busy, sram_re} !== 3'b100)
         $display("FAIL %s finish: got done/busy/re %b want 100", name, {done, busy, sram_re});
      else n_pass++;
      tick();
      n_checks++;
      if ({done, busy, window_valid} !== 3'b000)
         $display("FAIL %s after_finish: got done/busy/wv %b want 000", name, {done, busy, window_valid});
      else n_pass++;
      n_checks++;
      if (exp_addr.size() + exp_zero.size() != 0)
         $display("FAIL %s leftover_rows: got %0d pending want 0", name, exp_addr.size() + exp_zero.size());
      else n_pass++;
   endtask

   task automatic test_empty();
      reset_dut();
      mode = 1'b0; base_addr = 10'd5; row_cnt = '0; pad_top = '0; pad_bottom = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({done, busy, sram_re, buffer_we} !== 4'b1000)
         $display("FAIL empty c1: got done/busy/re/we %b want 1000", {done, busy, sram_re, buffer_we});
      else n_pass++;
      for (int c = 2; c <= 5; c++) begin
         tick();
         n_checks++;
         if ({done, busy, sram_re, buffer_we} !== 4'b0000)
            $display("FAIL empty c%0d: got done/busy/re/we %b want 0000", c, {done, busy, sram_re, buffer_we});
         else n_pass++;
      end
   endtask

   task automatic test_step_held();
      bit exp_re;
      bit exp_wv;
      bit exp_done;
      reset_dut();
      model_setup(1'b0, 300, 15, 0, 0);
      push_rows(15);
      mode = 1'b0; base_addr = 10'd300; row_cnt = 11'd15; pad_top = '0; pad_bottom = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      step  = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         exp_re   = (c <= 10) || (c >= 13 && c <= 25 && (c - 13) % 3 == 0);
         exp_wv   = (c >= 12 && c <= 27 && (c - 12) % 3 == 0);
         exp_done = (c == 28);
         n_checks++;
         if ({sram_re, window_valid, done, busy} !== {exp_re, exp_wv, exp_done, c <= 27})
            $display("FAIL step_held c%0d: got re/wv/done/busy %b want %b", c,
                     {sram_re, window_valid, done, busy}, {exp_re, exp_wv, exp_done, c <= 27});
         else n_pass++;
         tick();
      end
      step = 1'b0;
      n_checks++;
      if (exp_addr.size() + exp_zero.size() != 0)
         $display("FAIL step_held leftover_rows: got %0d pending want 0", exp_addr.size() + exp_zero.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      reset_dut();
      model_setup(1'b0, 100, 12, 2, 2);
      push_rows(m_p);
      mode = 1'b0; base_addr = 10'd100; row_cnt = 11'd12; pad_top = 4'd2; pad_bottom = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({sram_re, buffer_mode, buffer_we, fill_zero, window_valid, busy, done} !== 7'd0 || sram_addr !== '0)
         $display("FAIL reset_mid outputs: got %b addr %0d want all 0",
                  {sram_re, buffer_mode, buffer_we, fill_zero, window_valid, busy, done}, sram_addr);
      else n_pass++;
      rst = 1'b0;
      exp_addr.delete();
      exp_zero.delete();
      for (int c = 0; c < 12; c++) begin
         tick();
         n_checks++;
         if ({done, busy, sram_re} !== 3'b000)
            $display("FAIL reset_mid idle%0d: got done/busy/re %b want 000", c, {done, busy, sram_re});
         else n_pass++;
      end
      test_operation("restart", 1'b0, 100, 12, 2, 2, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_operation("mode0_pad", 1'b0, 100, 12, 2, 2, 1'b0, 1'b1);
      test_operation("mode1", 1'b1, 0, 4, 3, 3, 1'b0, 1'b1);
      test_operation("short", 1'b0, 40, 3, 0, 0, 1'b0, 1'b1);
      test_operation("ignore", 1'b0, 200, 12, 0, 0, 1'b1, 1'b1);
      test_operation("wrap", 1'b1, 1022, 4, 0, 0, 1'b0, 1'b1);
      test_empty();
      test_step_held();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
